// File: rtl/mc_ctrl_pkg.sv
// mc_pkg: shared definitions for the multi-cycle main controller.
//   - state_t    : controller state encodings (0..10, ILLEGAL = 15)
//   - OP_* / FN_*: opcode (IR[31:26]) and R-type funct (IR[5:0]) values
//   - ALU_*      : ALU operation codes driven on aluop
//   - SRCB_* / PCSRC_*: select codes for alu_src_b and pc_src
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_R     = 4'd7,
        S_WB_MEM   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_ILLEGAL  = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_SLT  = 3'd4;
    localparam logic [2:0] ALU_SLTU = 3'd5;
    localparam logic [2:0] ALU_LUI  = 3'd6;

    localparam logic [1:0] SRCB_BUS_B   = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    localparam logic [1:0] PCSRC_ALU     = 2'd0;
    localparam logic [1:0] PCSRC_ALU_OUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP    = 2'd2;

endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: unified memory port handshake between the controller and memory.
//   mem_req   : access request (controller -> memory)
//   mem_we    : 1 = write, 0 = read, meaningful only while mem_req = 1
//   iord      : address source, 0 = PC, 1 = ALU-out register
//   mem_ready : memory completes the current access this cycle
// Modports: master (controller side), slave (memory side).
interface mc_ctrl_if;

    logic mem_req;
    logic mem_we;
    logic iord;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output iord, input mem_ready);
    modport slave  (input mem_req, input mem_we, input iord, output mem_ready);

endinterface

// File: rtl/mc_ctrl_alu_dec.sv
// mc_alu_dec: combinational ALU-operation decoder for the execute states.
//   op, funct : instruction opcode and R-type function field
//   aluop     : ALU operation for EXEC_R (from funct) or EXEC_I (from op)
//   if_extend : immediate extension mode for I-type ALU instructions
//   legal     : 0 when the op/funct pair is not an implemented ALU instruction
module mc_alu_dec
    import mc_pkg::*;
#(
    parameter int ALUOP_W = 5
) (
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    output logic [ALUOP_W-1:0] aluop,
    output logic               if_extend,
    output logic               legal
);

    // R-type ops take their operation from funct; the three I-type ALU ops
    // take it from the opcode. ori/lui use zero extension, addiu sign extension.
    always_comb begin
        aluop     = ALUOP_W'(ALU_ADD);
        if_extend = 1'b0;
        legal     = 1'b1;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: aluop = ALUOP_W'(ALU_ADD);
                    FN_SUBU: aluop = ALUOP_W'(ALU_SUB);
                    FN_AND:  aluop = ALUOP_W'(ALU_AND);
                    FN_OR:   aluop = ALUOP_W'(ALU_OR);
                    FN_SLT:  aluop = ALUOP_W'(ALU_SLT);
                    FN_SLTU: aluop = ALUOP_W'(ALU_SLTU);
                    default: legal = 1'b0;
                endcase
            end
            OP_ADDIU: begin
                aluop     = ALUOP_W'(ALU_ADD);
                if_extend = 1'b1;
            end
            OP_ORI:  aluop = ALUOP_W'(ALU_OR);
            OP_LUI:  aluop = ALUOP_W'(ALU_LUI);
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle main controller sequencing a shared PC / IR / GPR /
// ALU / unified-memory datapath through fetch, decode, execute, memory and
// writeback states.
//   clock, reset : rising-edge clock, asynchronous active-low reset
//   mem          : memory handshake (mc_ctrl_if.master: mem_req/mem_we/iord out,
//                  mem_ready in)
//   op, funct, zero : instruction fields from the IR and the ALU zero flag
//   ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg,
//   alu_src_a, alu_src_b, if_extend, aluop : datapath controls
//   illegal      : sticky unsupported-instruction flag
//   state        : current state, for debug
// Optional: define MC_CTRL_PERF_EN to add the 32-bit cycle_cnt / instr_cnt
// performance counters.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int STATE_W = 4,
    parameter int ALUOP_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    mc_ctrl_if.master          mem,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic               if_extend,
    output logic [ALUOP_W-1:0] aluop,
    output logic               illegal,
    output logic [STATE_W-1:0] state
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0]        cycle_cnt,
    output logic [31:0]        instr_cnt
`endif
);

    state_t             cur;
    logic               mem_ready;
    logic [ALUOP_W-1:0] dec_aluop;
    logic               dec_if_extend;
    logic               dec_legal;
    logic               mem_req;
    logic               mem_we;
    logic               iord;

    assign mem_ready   = mem.mem_ready;
    assign mem.mem_req = mem_req;
    assign mem.mem_we  = mem_we;
    assign mem.iord    = iord;
    assign state       = STATE_W'(cur);

    mc_alu_dec #(
        .ALUOP_W   (ALUOP_W)
    ) u_alu_dec (
        .op        (op),
        .funct     (funct),
        .aluop     (dec_aluop),
        .if_extend (dec_if_extend),
        .legal     (dec_legal)
    );

    // State register and sticky illegal flag. The IR is stable from DECODE
    // until the next FETCH, so op can still steer MEM_ADDR and WB_R.
    // Unused encodings fall into ILLEGAL rather than silently recovering.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur     <= S_FETCH;
            illegal <= 1'b0;
        end else begin
            case (cur)
                S_FETCH: begin
                    if (mem_ready) cur <= S_DECODE;
                end
                S_DECODE: begin
                    case (op)
                        OP_RTYPE:                 cur <= S_EXEC_R;
                        OP_ADDIU, OP_ORI, OP_LUI: cur <= S_EXEC_I;
                        OP_LW, OP_SW:             cur <= S_MEM_ADDR;
                        OP_BEQ:                   cur <= S_BRANCH;
                        OP_J:                     cur <= S_JUMP;
                        default: begin
                            cur     <= S_ILLEGAL;
                            illegal <= 1'b1;
                        end
                    endcase
                end
                S_EXEC_R: begin
                    if (dec_legal) begin
                        cur <= S_WB_R;
                    end else begin
                        cur     <= S_ILLEGAL;
                        illegal <= 1'b1;
                    end
                end
                S_EXEC_I:   cur <= S_WB_R;
                S_MEM_ADDR: cur <= (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD: begin
                    if (mem_ready) cur <= S_WB_MEM;
                end
                S_MEM_WR: begin
                    if (mem_ready) cur <= S_FETCH;
                end
                S_WB_R, S_WB_MEM, S_BRANCH, S_JUMP: cur <= S_FETCH;
                S_ILLEGAL:  cur <= S_ILLEGAL;
                default: begin
                    cur     <= S_ILLEGAL;
                    illegal <= 1'b1;
                end
            endcase
        end
    end

    // Moore decode of the datapath controls from the current state. Only the
    // FETCH IR/PC loads depend on mem_ready and the branch PC load on zero.
    // The enables are forced low while reset is held, because FETCH (the reset
    // state) would otherwise request memory during reset.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PCSRC_ALU;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_BUS_B;
        if_extend  = 1'b0;
        aluop      = ALUOP_W'(ALU_ADD);
        case (cur)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
                if_extend = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_BUS_B;
                aluop     = dec_aluop;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                aluop     = dec_aluop;
                if_extend = dec_if_extend;
            end
            S_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = (op == OP_RTYPE);
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                if_extend = 1'b1;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_BUS_B;
                aluop     = ALUOP_W'(ALU_SUB);
                pc_src    = PCSRC_ALU_OUT;
                pc_write  = zero;
            end
            S_JUMP: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
            end
            default: ;
        endcase
        if (!reset) begin
            mem_req   = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
        end
    end

`ifdef MC_CTRL_PERF_EN
    logic instr_done;

    // An instruction retires on the edge that returns the FSM to FETCH.
    assign instr_done = (cur == S_WB_R) || (cur == S_WB_MEM) ||
                        (cur == S_BRANCH) || (cur == S_JUMP) ||
                        ((cur == S_MEM_WR) && mem_ready);

    // Free-running counters; cycle_cnt freezes once the controller has
    // locked up in ILLEGAL.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= 32'd0;
            instr_cnt <= 32'd0;
        end else begin
            if (cur != S_ILLEGAL) cycle_cnt <= cycle_cnt + 32'd1;
            if (instr_done)       instr_cnt <= instr_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: self-checking bench for mc_ctrl. Each directed instruction
// pushes its expected per-cycle control vector into a scoreboard queue; the
// queue is drained one cycle at a time, comparing state and controls.
// Define MC_CTRL_PERF_EN to also exercise the performance counters.
module tb_mc_ctrl;

    localparam logic [3:0] ST_FETCH = 4'd0,  ST_DECODE = 4'd1, ST_EXEC_R = 4'd2,
                           ST_EXEC_I = 4'd3, ST_MEM_ADDR = 4'd4, ST_MEM_RD = 4'd5,
                           ST_MEM_WR = 4'd6, ST_WB_R = 4'd7,  ST_WB_MEM = 4'd8,
                           ST_BRANCH = 4'd9, ST_JUMP = 4'd10, ST_ILLEGAL = 4'd15;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       if_extend;
        logic [4:0] aluop;
        logic       illegal;
    } ctl_t;

    typedef struct {
        string      name;
        logic [3:0] st;
        logic [5:0] op;
        logic [5:0] funct;
        logic       z;
        logic       rdy;
        ctl_t       exp;
        ctl_t       msk;
    } item_t;

    item_t sb[$];
    int    tests = 0;
    int    fails = 0;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op    = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero  = 1'b0;
    logic       ir_write, pc_write, reg_write, reg_dst, mem_to_reg;
    logic       alu_src_a, if_extend, illegal;
    logic [1:0] pc_src, alu_src_b;
    logic [4:0] aluop;
    logic [3:0] state;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    mc_ctrl_if mem_bus ();

    mc_ctrl #(
        .STATE_W    (4),
        .ALUOP_W    (5)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .mem        (mem_bus),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .if_extend  (if_extend),
        .aluop      (aluop),
        .illegal    (illegal),
        .state      (state)
`ifdef MC_CTRL_PERF_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
`endif
    );

    always #5 clock = ~clock;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected controls per state, with a mask of the fields that state defines.
    function automatic void model(input logic [3:0] st, input logic [5:0] o, input logic [5:0] f,
                                  input logic z, input logic rdy, output ctl_t e, output ctl_t m);
        e = '0;
        m = '0;
        m.mem_req = 1'b1; m.ir_write = 1'b1; m.pc_write = 1'b1; m.reg_write = 1'b1; m.illegal = 1'b1;
        case (st)
            ST_FETCH: begin
                m.mem_we = 1'b1; m.iord = 1'b1; m.alu_src_a = 1'b1; m.alu_src_b = '1;
                m.aluop = '1; m.pc_src = '1;
                e.mem_req = 1'b1; e.alu_src_b = 2'd1; e.ir_write = rdy; e.pc_write = rdy;
            end
            ST_DECODE: begin
                m.alu_src_a = 1'b1; m.alu_src_b = '1; m.aluop = '1; m.if_extend = 1'b1;
                e.alu_src_b = 2'd3; e.if_extend = 1'b1;
            end
            ST_EXEC_R: begin
                m.alu_src_a = 1'b1; m.alu_src_b = '1; m.aluop = '1;
                e.alu_src_a = 1'b1;
                case (f)
                    6'b100001: e.aluop = 5'd0;
                    6'b100011: e.aluop = 5'd1;
                    6'b100100: e.aluop = 5'd2;
                    6'b100101: e.aluop = 5'd3;
                    6'b101010: e.aluop = 5'd4;
                    6'b101011: e.aluop = 5'd5;
                    default:   m.aluop = '0;
                endcase
            end
            ST_EXEC_I: begin
                m.alu_src_a = 1'b1; m.alu_src_b = '1; m.aluop = '1; m.if_extend = 1'b1;
                e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
                if (o == 6'b001001) begin e.aluop = 5'd0; e.if_extend = 1'b1; end
                else if (o == 6'b001101) e.aluop = 5'd3;
                else e.aluop = 5'd6;
            end
            ST_WB_R: begin
                m.mem_to_reg = 1'b1; m.reg_dst = 1'b1;
                e.reg_write = 1'b1; e.reg_dst = (o == 6'd0);
            end
            ST_MEM_ADDR: begin
                m.alu_src_a = 1'b1; m.alu_src_b = '1; m.aluop = '1; m.if_extend = 1'b1;
                e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.if_extend = 1'b1;
            end
            ST_MEM_RD: begin
                m.mem_we = 1'b1; m.iord = 1'b1;
                e.mem_req = 1'b1; e.iord = 1'b1;
            end
            ST_MEM_WR: begin
                m.mem_we = 1'b1; m.iord = 1'b1;
                e.mem_req = 1'b1; e.mem_we = 1'b1; e.iord = 1'b1;
            end
            ST_WB_MEM: begin
                m.mem_to_reg = 1'b1; m.reg_dst = 1'b1;
                e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
            end
            ST_BRANCH: begin
                m.alu_src_a = 1'b1; m.alu_src_b = '1; m.aluop = '1; m.pc_src = '1;
                e.alu_src_a = 1'b1; e.aluop = 5'd1; e.pc_src = 2'd1; e.pc_write = z;
            end
            ST_JUMP: begin
                m.pc_src = '1;
                e.pc_src = 2'd2; e.pc_write = 1'b1;
            end
            default: e.illegal = 1'b1;
        endcase
    endfunction

    // Queue one expected cycle together with the inputs that produce it.
    task automatic apply_stimulus(input string name, input logic [3:0] st, input logic [5:0] o,
                                  input logic [5:0] f, input logic z, input logic rdy);
        item_t it;
        it.name = name; it.st = st; it.op = o; it.funct = f; it.z = z; it.rdy = rdy;
        model(st, o, f, z, rdy, it.exp, it.msk);
        sb.push_back(it);
    endtask

    // Drain the scoreboard: drive each cycle's inputs after the rising edge,
    // compare at the falling edge.
    task automatic run_queue();
        item_t it;
        ctl_t  obs;
        int    k = 0;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            op = it.op; funct = it.funct; zero = it.z; mem_bus.mem_ready = it.rdy;
            @(negedge clock);
            obs = '{mem_req: mem_bus.mem_req, mem_we: mem_bus.mem_we, iord: mem_bus.iord,
                    ir_write: ir_write, pc_write: pc_write, pc_src: pc_src,
                    reg_write: reg_write, reg_dst: reg_dst, mem_to_reg: mem_to_reg,
                    alu_src_a: alu_src_a, alu_src_b: alu_src_b, if_extend: if_extend,
                    aluop: aluop, illegal: illegal};
            check_output($sformatf("%s.c%0d.state", it.name, k), 32'(state), 32'(it.st));
            check_output($sformatf("%s.c%0d.ctl", it.name, k), 32'(obs & it.msk), 32'(it.exp & it.msk));
            k++;
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check_in_reset(input string tag);
        check_output({tag, ".state"}, 32'(state), 32'(ST_FETCH));
        check_output({tag, ".enables"}, 32'({mem_bus.mem_req, ir_write, pc_write, reg_write}), 32'd0);
        check_output({tag, ".illegal"}, 32'(illegal), 32'd0);
    endtask

    // Assert reset asynchronously away from the clock edge, hold it over one
    // edge, release it just after the next edge.
    task automatic reset_pulse(input string tag);
        reset = 1'b0;
        mem_bus.mem_ready = 1'b1;
        #1;
        check_in_reset({tag, ".async"});
        @(negedge clock);
        check_in_reset({tag, ".held"});
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic push_alu(input string name, input logic [5:0] o, input logic [5:0] f);
        apply_stimulus(name, ST_FETCH, o, f, 1'b0, 1'b1);
        apply_stimulus(name, ST_DECODE, o, f, 1'b0, 1'b1);
        apply_stimulus(name, (o == 6'd0) ? ST_EXEC_R : ST_EXEC_I, o, f, 1'b0, 1'b1);
        apply_stimulus(name, ST_WB_R, o, f, 1'b0, 1'b1);
    endtask

    initial begin
        logic [5:0] fn_list [6];
        fn_list = '{6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101010, 6'b101011};
        mem_bus.mem_ready = 1'b0;

        #2;
        check_in_reset("por");
        @(negedge clock);
        check_in_reset("por2");
        @(posedge clock);
        #1;
        reset = 1'b1;

        // lw interrupted by reset while waiting in MEM_RD
        apply_stimulus("lw_abort", ST_FETCH, 6'b100011, 6'd0, 1'b0, 1'b1);
        apply_stimulus("lw_abort", ST_DECODE, 6'b100011, 6'd0, 1'b0, 1'b1);
        apply_stimulus("lw_abort", ST_MEM_ADDR, 6'b100011, 6'd0, 1'b0, 1'b1);
        apply_stimulus("lw_abort", ST_MEM_RD, 6'b100011, 6'd0, 1'b0, 1'b0);
        run_queue();
        reset_pulse("rst_mid_mem");

        // R-type ALU instructions, one per funct
        foreach (fn_list[i]) push_alu($sformatf("rtype%0d", i), 6'b000000, fn_list[i]);
        run_queue();

        // lw with two wait states in MEM_RD
        apply_stimulus("lw_wait", ST_FETCH, 6'b100011, 6'd0, 1'b0, 1'b1);
        apply_stimulus("lw_wait", ST_DECODE, 6'b100011, 6'd0, 1'b0, 1'b1);
        apply_stimulus("lw_wait", ST_MEM_ADDR, 6'b100011, 6'd0, 1'b0, 1'b1);
        apply_stimulus("lw_wait", ST_MEM_RD, 6'b100011, 6'd0, 1'b0, 1'b0);
        apply_stimulus("lw_wait", ST_MEM_RD, 6'b100011, 6'd0, 1'b0, 1'b0);
        apply_stimulus("lw_wait", ST_MEM_RD, 6'b100011, 6'd0, 1'b0, 1'b1);
        apply_stimulus("lw_wait", ST_WB_MEM, 6'b100011, 6'd0, 1'b0, 1'b1);
        // sw with a fetch wait and a write wait
        apply_stimulus("sw_wait", ST_FETCH, 6'b101011, 6'd0, 1'b0, 1'b0);
        apply_stimulus("sw_wait", ST_FETCH, 6'b101011, 6'd0, 1'b0, 1'b1);
        apply_stimulus("sw_wait", ST_DECODE, 6'b101011, 6'd0, 1'b0, 1'b1);
        apply_stimulus("sw_wait", ST_MEM_ADDR, 6'b101011, 6'd0, 1'b0, 1'b1);
        apply_stimulus("sw_wait", ST_MEM_WR, 6'b101011, 6'd0, 1'b0, 1'b0);
        apply_stimulus("sw_wait", ST_MEM_WR, 6'b101011, 6'd0, 1'b0, 1'b1);
        // I-type ALU instructions
        push_alu("addiu", 6'b001001, 6'b111111);
        push_alu("ori", 6'b001101, 6'b000000);
        push_alu("lui", 6'b001111, 6'b100001);
        // beq taken then not taken, then j
        apply_stimulus("beq_t", ST_FETCH, 6'b000100, 6'd0, 1'b1, 1'b1);
        apply_stimulus("beq_t", ST_DECODE, 6'b000100, 6'd0, 1'b1, 1'b1);
        apply_stimulus("beq_t", ST_BRANCH, 6'b000100, 6'd0, 1'b1, 1'b1);
        apply_stimulus("beq_n", ST_FETCH, 6'b000100, 6'd0, 1'b0, 1'b1);
        apply_stimulus("beq_n", ST_DECODE, 6'b000100, 6'd0, 1'b0, 1'b1);
        apply_stimulus("beq_n", ST_BRANCH, 6'b000100, 6'd0, 1'b0, 1'b1);
        apply_stimulus("j", ST_FETCH, 6'b000010, 6'd0, 1'b0, 1'b1);
        apply_stimulus("j", ST_DECODE, 6'b000010, 6'd0, 1'b0, 1'b1);
        apply_stimulus("j", ST_JUMP, 6'b000010, 6'd0, 1'b0, 1'b1);
        // R-type with an unsupported funct locks up after EXEC_R
        apply_stimulus("bad_fn", ST_FETCH, 6'b000000, 6'b000000, 1'b0, 1'b1);
        apply_stimulus("bad_fn", ST_DECODE, 6'b000000, 6'b000000, 1'b0, 1'b1);
        apply_stimulus("bad_fn", ST_EXEC_R, 6'b000000, 6'b000000, 1'b0, 1'b1);
        apply_stimulus("bad_fn", ST_ILLEGAL, 6'b000000, 6'b000000, 1'b0, 1'b1);
        apply_stimulus("bad_fn", ST_ILLEGAL, 6'b000000, 6'b000000, 1'b0, 1'b1);
        run_queue();
        reset_pulse("rst_bad_fn");

        // unsupported opcode: ILLEGAL is absorbing for 20 cycles
        apply_stimulus("bad_op", ST_FETCH, 6'b111111, 6'd0, 1'b0, 1'b1);
        apply_stimulus("bad_op", ST_DECODE, 6'b111111, 6'd0, 1'b0, 1'b1);
        for (int k = 0; k < 20; k++)
            apply_stimulus("bad_op", ST_ILLEGAL, 6'b111111, 6'd0, 1'(k % 2), 1'(k % 2));
        run_queue();
        reset_pulse("rst_bad_op");

`ifdef MC_CTRL_PERF_EN
        // addiu (4) + sw (4) + j (3) with no wait states
        push_alu("p_addiu", 6'b001001, 6'd0);
        apply_stimulus("p_sw", ST_FETCH, 6'b101011, 6'd0, 1'b0, 1'b1);
        apply_stimulus("p_sw", ST_DECODE, 6'b101011, 6'd0, 1'b0, 1'b1);
        apply_stimulus("p_sw", ST_MEM_ADDR, 6'b101011, 6'd0, 1'b0, 1'b1);
        apply_stimulus("p_sw", ST_MEM_WR, 6'b101011, 6'd0, 1'b0, 1'b1);
        apply_stimulus("p_j", ST_FETCH, 6'b000010, 6'd0, 1'b0, 1'b1);
        apply_stimulus("p_j", ST_DECODE, 6'b000010, 6'd0, 1'b0, 1'b1);
        apply_stimulus("p_j", ST_JUMP, 6'b000010, 6'd0, 1'b0, 1'b1);
        run_queue();
        check_output("perf.instr_cnt", instr_cnt, 32'd3);
        check_output("perf.cycle_cnt", cycle_cnt, 32'd11);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle main controller that sequences the shared CPU datapath (PC, instruction register, GPR file, ALU, unified memory port) through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states. It replaces the combinational single-cycle decoder when the datapath moves to one ALU and one memory port shared across cycles. Instruction fetch and data accesses use a single req/ready memory handshake, so wait states are supported.

Parameters:
STATE_W, 4, width of the state register and state debug port
ALUOP_W, 5, width of the aluop output; the ALU owns the encoding

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
op  input  6  IR[31:26], valid from DECODE onward
funct  input  6  IR[5:0]
zero  input  1  ALU zero flag, sampled in BRANCH
mem_ready  input  1  memory completes the current access this cycle
mem_req  output  1  memory access request
mem_we  output  1  1 = write, 0 = read; valid only while mem_req=1
iord  output  1  memory address source: 0 = PC, 1 = ALU-out register
ir_write  output  1  load the IR
pc_write  output  1  load the PC
pc_src  output  2  0 = ALU result, 1 = ALU-out (branch target), 2 = jump target
reg_write  output  1  GPR write enable
reg_dst  output  1  0 = rt, 1 = rd
mem_to_reg  output  1  0 = ALU-out, 1 = memory data register
alu_src_a  output  1  0 = PC, 1 = bus_a
alu_src_b  output  2  0 = bus_b, 1 = constant 4, 2 = imm_32, 3 = imm_32<<2
if_extend  output  1  1 = sign-extend imm_16, 0 = zero-extend
aluop  output  ALUOP_W  ALU operation
illegal  output  1  sticky unsupported-opcode flag
state  output  STATE_W  current state, for debug

Behaviour:
- States (encoded 0..10): FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_R, WB_MEM, BRANCH, JUMP; ILLEGAL = 15.
- Reset asserted (reset=0): state=FETCH, illegal=0. All enables (mem_req, ir_write, pc_write, reg_write) must read 0 while reset is low; a reset in mid-instruction abandons it immediately.
- Outputs are Moore, decoded from state. Two exceptions are qualified by mem_ready: ir_write and pc_write in FETCH, and all state advances out of memory states.
- FETCH: mem_req=1, mem_we=0, iord=0, alu_src_a=0, alu_src_b=1, aluop=ADD, pc_src=0. Hold while mem_ready=0. On mem_ready=1: ir_write=1, pc_write=1, next state DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, aluop=ADD, if_extend=1 (precomputes the branch target). Next state by op:
  - 000000 -> EXEC_R
  - 001001 addiu, 001101 ori, 001111 lui -> EXEC_I
  - 100011 lw, 101011 sw -> MEM_ADDR
  - 000100 beq -> BRANCH
  - 000010 j -> JUMP
  - anything else -> ILLEGAL
- EXEC_R: alu_src_a=1, alu_src_b=0. aluop from funct: 100001 ADD, 100011 SUB, 100100 AND, 100101 OR, 101010 SLT, 101011 SLTU. Any other funct -> ILLEGAL; otherwise -> WB_R.
- EXEC_I: alu_src_a=1, alu_src_b=2. addiu: ADD with if_extend=1. ori: OR with if_extend=0. lui: LUI with if_extend=0. Next state WB_R.
- WB_R: reg_write=1, mem_to_reg=0. reg_dst=1 for R-type, 0 otherwise. Next state FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, if_extend=1, aluop=ADD. Next state MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_req=1, mem_we=0, iord=1. Hold until mem_ready, then -> WB_MEM.
- MEM_WR: mem_req=1, mem_we=1, iord=1. Hold until mem_ready, then -> FETCH.
- WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, aluop=SUB, pc_src=1. pc_write=zero. Next state FETCH.
- JUMP: pc_src=2, pc_write=1. Next state FETCH.
- ILLEGAL: illegal=1; absorbing until reset; all enables 0.
- Latency with zero wait states: R-type/I-type 4 cycles, lw 5, sw 4, beq 3, j 3. Each cycle with mem_ready=0 in FETCH/MEM_RD/MEM_WR adds one cycle.
- Write enables must never be asserted in two consecutive states except where listed above.

Optional Feature:
MC_CTRL_PERF_EN.
- Defined: adds 32-bit outputs cycle_cnt and instr_cnt, both cleared by reset. cycle_cnt increments every cycle except in ILLEGAL. instr_cnt increments on each transition into FETCH from a completing state (WB_R, WB_MEM, MEM_WR on mem_ready, BRANCH, JUMP). Both wrap modulo 2^32.
- Undefined: ports and logic are absent.

Decomposition:
- Package mc_pkg holds: state encodings, opcode and funct constants, ALU operation codes (ADD=0, SUB=1, AND=2, OR=3, SLT=4, SLTU=5, LUI=6), and the alu_src_b/pc_src select codes.
- Sub-module mc_alu_dec (combinational funct/op -> aluop, if_extend, legal) is natural; the FSM stays in mc_ctrl.

Test Plan:
- reset low mid-MEM_RD, then released -> state=FETCH and all enables 0 while reset is low; first cycle after release drives mem_req=1, iord=0.
- op=000000, funct=100001, mem_ready=1 always -> states FETCH, DECODE, EXEC_R, WB_R over exactly 4 cycles; reg_write=1, reg_dst=1 only in WB_R.
- lw with mem_ready=0 for 2 cycles in MEM_RD -> MEM_RD held 3 cycles; total 7 cycles; reg_write=1, mem_to_reg=1 in WB_MEM.
- beq with zero=1, then zero=0 -> pc_write=1 with pc_src=1 in the first BRANCH, pc_write=0 in the second; each instruction takes 3 cycles.
- op=111111 -> ILLEGAL after DECODE; illegal=1 and stays 1 for 20 cycles; mem_req stays 0.
- With MC_CTRL_PERF_EN defined: addiu, sw, j with no wait states -> instr_cnt=3, cycle_cnt=11.
